// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the seven-segment display scheduler.
// BLANK digit code, SCORE/MSG state encoding, counter width helper, score saturation.
package sevenseg_pkg;

  localparam logic [3:0] BLANK = 4'hF;

  localparam logic [0:0] ST_SCORE = 1'b0;
  localparam logic [0:0] ST_MSG   = 1'b1;

  localparam int BIN_W = 7;
  localparam int BCD_W = 8;

  // Counter width for a range of n values; never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Two display digits can only show up to 99.
  function automatic logic [BIN_W-1:0] sat99(
    input logic [BIN_W-1:0] b
  );
    return (b > 7'd99) ? 7'd99 : b;
  endfunction

endpackage

// File: rtl/sevenseg_disp_sched_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one load cycle then 7 shift/add-3 cycles.
// Ports: clk, rst, i_start, i_bin[6:0] -> o_busy, o_done (pulse), o_bcd[7:0], o_last[6:0].
module bin2bcd_seq
  import sevenseg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd,
  output logic [BIN_W-1:0] o_last
);

  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_cnt;
  logic [14:0]      r_sh;
  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [BIN_W-1:0] r_last;

  logic [3:0]       w_hi;
  logic [3:0]       w_lo;
  logic [14:0]      w_adj;
  logic [14:0]      w_shift;

  // Inputs are saturated to <=99, so no hundreds nibble is needed.
  always_comb begin
    w_hi    = r_sh[14:11];
    w_lo    = r_sh[10:7];
    if (w_hi >= 4'd5) w_hi = w_hi + 4'd3;
    if (w_lo >= 4'd5) w_lo = w_lo + 4'd3;
    w_adj   = {w_hi, w_lo, r_sh[6:0]};
    w_shift = {w_adj[13:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_sh   <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
      r_last <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy <= 1'b1;
          r_cnt  <= '0;
          r_sh   <= {8'd0, i_bin};
          r_bin  <= i_bin;
        end
      end else begin
        r_sh  <= w_shift;
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd6) begin
          // BCD result and its source value commit together.
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_bcd  <= w_shift[14:7];
          r_last <= r_bin;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;
  assign o_last = r_last;

endmodule

// File: rtl/sevenseg_disp_sched.sv
// Display scheduler: scan_en strobe, score->BCD, score/message arbitration for 2-digit mux.
// In: clk, rst, i_score_bin, i_msg_req/bcd/blink. Out: o_msg_ack, o_scan_en, o_d3..d0, o_dp3..dp0, o_msg_active.
module sevenseg_disp_sched
  import sevenseg_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 4_000,
  parameter int HOLD_TICKS  = 6_000,
  parameter int BLINK_TICKS = 1_000
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] i_score_bin,
  input  logic             i_msg_req,
  input  logic [BCD_W-1:0] i_msg_bcd,
  input  logic             i_msg_blink,
  output logic             o_msg_ack,
  output logic             o_scan_en,
  output logic [3:0]       o_d3,
  output logic [3:0]       o_d2,
  output logic [3:0]       o_d1,
  output logic [3:0]       o_d0,
  output logic             o_dp3,
  output logic             o_dp2,
  output logic             o_dp1,
  output logic             o_dp0,
  output logic             o_msg_active
);

  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int DIV_W   = cnt_w(DIV);
  localparam int HOLD_W  = cnt_w(HOLD_TICKS);
  localparam int BLINK_W = cnt_w(BLINK_TICKS);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_PRE    = DIV_W'(DIV - 2);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [DIV_W-1:0]   r_div;
  logic               r_scan_en;
  logic [0:0]         r_state;
  logic [HOLD_W-1:0]  r_hold;
  logic [BLINK_W-1:0] r_bcnt;
  logic               r_phase;
  logic [BCD_W-1:0]   r_mdig;
  logic               r_mblink;
  logic               r_msg_ack;
  logic               r_msg_active;
  logic [3:0]         r_d1;
  logic [3:0]         r_d0;
  logic               r_dp0;

  logic               w_tick;
  logic [BIN_W-1:0]   w_sat;
  logic               w_busy;
  logic               w_done;
  logic [BCD_W-1:0]   w_bcd;
  logic [BIN_W-1:0]   w_last;
  logic               w_start;
  logic               w_accept;

  logic [0:0]         w_state_n;
  logic [HOLD_W-1:0]  w_hold_n;
  logic [BLINK_W-1:0] w_bcnt_n;
  logic               w_phase_n;
  logic [BCD_W-1:0]   w_mdig_n;
  logic               w_mblink_n;
  logic               w_msg_n;
  logic [BCD_W-1:0]   w_dig_n;

  // Tick is the cycle in which o_scan_en is high.
  assign w_tick = (r_div == DIV_LAST);
  assign w_sat  = sat99(i_score_bin);

  // The done cycle counts as not idle so the compare sees the new last value.
  assign w_start  = !w_busy && !w_done && (w_sat != w_last);

  // Requests are ignored while ack is high, giving the requester a cycle to drop.
  assign w_accept = i_msg_req && !r_msg_ack;

  bin2bcd_seq u_b2b (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_bin   (w_sat),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd),
    .o_last  (w_last)
  );

  // Preemption takes priority over hold expiry.
  always_comb begin
    w_state_n  = r_state;
    w_hold_n   = r_hold;
    w_bcnt_n   = r_bcnt;
    w_phase_n  = r_phase;
    w_mdig_n   = r_mdig;
    w_mblink_n = r_mblink;
    if (w_accept) begin
      w_state_n  = ST_MSG;
      w_hold_n   = '0;
      w_bcnt_n   = '0;
      w_phase_n  = 1'b1;
      w_mdig_n   = i_msg_bcd;
      w_mblink_n = i_msg_blink;
    end else if (r_state == ST_MSG && w_tick) begin
      if (r_hold == HOLD_LAST) begin
        w_state_n = ST_SCORE;
      end else begin
        w_hold_n = r_hold + HOLD_W'(1);
      end
      if (r_bcnt == BLINK_LAST) begin
        w_bcnt_n  = '0;
        w_phase_n = !r_phase;
      end else begin
        w_bcnt_n = r_bcnt + BLINK_W'(1);
      end
    end
  end

  // Output registers load from next-state so they follow inputs by one clk.
  always_comb begin
    w_msg_n = (w_state_n == ST_MSG);
    w_dig_n = w_bcd;
    if (w_msg_n) begin
      if (w_mblink_n && !w_phase_n) begin
        w_dig_n = {BLANK, BLANK};
      end else begin
        w_dig_n = w_mdig_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div        <= '0;
      r_scan_en    <= 1'b0;
      r_state      <= ST_SCORE;
      r_hold       <= '0;
      r_bcnt       <= '0;
      r_phase      <= 1'b0;
      r_mdig       <= '0;
      r_mblink     <= 1'b0;
      r_msg_ack    <= 1'b0;
      r_msg_active <= 1'b0;
      r_d1         <= 4'h0;
      r_d0         <= 4'h0;
      r_dp0        <= 1'b0;
    end else begin
      r_div        <= w_tick ? '0 : r_div + DIV_W'(1);
      r_scan_en    <= (r_div == DIV_PRE);
      r_state      <= w_state_n;
      r_hold       <= w_hold_n;
      r_bcnt       <= w_bcnt_n;
      r_phase      <= w_phase_n;
      r_mdig       <= w_mdig_n;
      r_mblink     <= w_mblink_n;
      r_msg_ack    <= w_accept;
      r_msg_active <= w_msg_n;
      r_d1         <= w_dig_n[7:4];
      r_d0         <= w_dig_n[3:0];
      r_dp0        <= w_msg_n;
    end
  end

  assign o_msg_ack    = r_msg_ack;
  assign o_scan_en    = r_scan_en;
  assign o_d3         = BLANK;
  assign o_d2         = BLANK;
  assign o_d1         = r_d1;
  assign o_d0         = r_d0;
  assign o_dp3        = 1'b0;
  assign o_dp2        = 1'b0;
  assign o_dp1        = 1'b0;
  assign o_dp0        = r_dp0;
  assign o_msg_active = r_msg_active;

endmodule
